cache_requester: RTL and testbench

- Processor-side initiator for the cache up-interface: it drives the address, enable, write and write-data lines into an L1 cache and collects read data and completions back.
- It buffers commands from a testbench or core in a small FIFO and issues them one at a time.
- It enforces the enable hold/release protocol, measures per-request latency, times out hung requests and keeps completion/timeout statistics.
- It sits between a command source and L1, replacing hand-written enable/addr sequencing in system benches.

---
 rtl/cache_requester.sv | 221 ++++++++++++++++++++++
 tb/tb_cache_requester.sv | 284 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cache_requester.sv
// Processor-side initiator for the L1 cache up-interface.
// Queues commands, sequences enable/addr, times out hung requests.
module cache_requester #(
  parameter int ADDR_LENGTH = 11,
  parameter int RETURN_SIZE = 32,
  parameter int FIFO_DEPTH  = 4,
  parameter int TIMEOUT     = 255,
  parameter int GAP_CYCLES  = 1
) (
  input  logic                           clock,
  input  logic                           reset,
  input  logic                           cmdValid,
  output logic                           cmdReady,
  input  logic                           cmdWrite,
  input  logic [ADDR_LENGTH-1:0]         cmdAddr,
  input  logic [RETURN_SIZE-1:0]         cmdData,
  output logic [ADDR_LENGTH-1:0]         addrOut,
  output logic [RETURN_SIZE-1:0]         dataOut,
  output logic                           enableOut,
  output logic                           writeOut,
  input  logic [RETURN_SIZE-1:0]         dataIn,
  input  logic                           fetchComplete,
  input  logic                           writeComplete,
  output logic                           respValid,
  output logic                           respWrite,
  output logic [RETURN_SIZE-1:0]         respData,
  output logic [$clog2(TIMEOUT+1)-1:0]   respLatency,
  output logic                           respTimeout,
  output logic [15:0]                    doneCount,
  output logic [15:0]                    timeoutCount,
  output logic                           busy
);

  localparam int LW = $clog2(TIMEOUT+1);
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int GW = $clog2(GAP_CYCLES+1);

  localparam logic [1:0] IDLE    = 2'd0;
  localparam logic [1:0] ISSUE   = 2'd1;
  localparam logic [1:0] RELEASE = 2'd2;

  typedef struct packed {
    logic                   wr;
    logic [ADDR_LENGTH-1:0] addr;
    logic [RETURN_SIZE-1:0] data;
  } cmd_t;

  cmd_t mem_q [FIFO_DEPTH];

  logic [PW:0]   wp_q, wp_d, rp_q, rp_d;
  logic [1:0]    state_q, state_d;
  logic [LW-1:0] lat_q, lat_d;
  logic [GW-1:0] gap_q, gap_d;

  logic [ADDR_LENGTH-1:0] addr_q, addr_d;
  logic [RETURN_SIZE-1:0] data_q, data_d;
  logic                   en_q, en_d;
  logic                   wr_q, wr_d;
  logic                   rv_q, rv_d;
  logic                   rw_q, rw_d;
  logic [RETURN_SIZE-1:0] rd_q, rd_d;
  logic [LW-1:0]          rl_q, rl_d;
  logic                   rt_q, rt_d;
  logic [15:0]            dc_q, dc_d;
  logic [15:0]            tc_q, tc_d;
  logic                   busy_q, busy_d;

  logic empty, full, push, pop, launch;
  logic done, tmo_hit;
  cmd_t head, incoming;

  // Extra MSB on each pointer separates full from empty.
  assign empty = (wp_q == rp_q);
  assign full  = (wp_q[PW] != rp_q[PW]) &&
                 (wp_q[PW-1:0] == rp_q[PW-1:0]);

  assign cmdReady = ~full;
  assign push     = cmdValid & ~full;
  assign head     = mem_q[rp_q[PW-1:0]];
  assign incoming = '{wr: cmdWrite, addr: cmdAddr, data: cmdData};

  assign done = (state_q == ISSUE) &&
                (fetchComplete || (wr_q && writeComplete));
  assign tmo_hit = (state_q == ISSUE) && !done &&
                   (lat_q == LW'(TIMEOUT-1));

  always_comb begin
    state_d = state_q;
    lat_d   = lat_q;
    gap_d   = gap_q;
    addr_d  = addr_q;
    data_d  = data_q;
    en_d    = en_q;
    wr_d    = wr_q;
    rv_d    = 1'b0;
    rw_d    = rw_q;
    rd_d    = rd_q;
    rl_d    = rl_q;
    rt_d    = rt_q;
    dc_d    = dc_q;
    tc_d    = tc_q;
    launch  = 1'b0;
    unique case (1'b1)
      (state_q == IDLE): begin
        launch = !empty;
      end
      (state_q == ISSUE): begin
        if (done) begin
          rv_d    = 1'b1;
          rw_d    = wr_q;
          rd_d    = wr_q ? '0 : dataIn;
          rl_d    = lat_q + LW'(1);
          rt_d    = 1'b0;
          dc_d    = (dc_q == 16'hFFFF) ? dc_q : dc_q + 16'd1;
          en_d    = 1'b0;
          wr_d    = 1'b0;
          gap_d   = '0;
          state_d = RELEASE;
        end else if (tmo_hit) begin
          rv_d    = 1'b1;
          rw_d    = wr_q;
          rd_d    = '0;
          rl_d    = LW'(TIMEOUT);
          rt_d    = 1'b1;
          tc_d    = (tc_q == 16'hFFFF) ? tc_q : tc_q + 16'd1;
          en_d    = 1'b0;
          wr_d    = 1'b0;
          gap_d   = '0;
          state_d = RELEASE;
        end else if (lat_q != LW'(TIMEOUT)) begin
          lat_d = lat_q + LW'(1);
        end
      end
      (state_q == RELEASE): begin
        // Last gap cycle may launch directly so the low gap is exact.
        if (gap_q == GW'(GAP_CYCLES-1)) begin
          if (!empty) launch = 1'b1;
          else        state_d = IDLE;
        end else begin
          gap_d = gap_q + GW'(1);
        end
      end
      default: begin
        state_d = IDLE;
        en_d    = 1'b0;
        wr_d    = 1'b0;
      end
    endcase
    if (launch) begin
      en_d    = 1'b1;
      wr_d    = head.wr;
      addr_d  = head.addr;
      data_d  = head.data;
      lat_d   = '0;
      state_d = ISSUE;
    end
  end

  assign pop    = launch;
  assign wp_d   = wp_q + {{PW{1'b0}}, push};
  assign rp_d   = rp_q + {{PW{1'b0}}, pop};
  assign busy_d = !((state_d == IDLE) && (wp_d == rp_d));

  always_ff @(posedge clock) begin
    if (push) mem_q[wp_q[PW-1:0]] <= incoming;
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      wp_q    <= '0;
      rp_q    <= '0;
      state_q <= IDLE;
      lat_q   <= '0;
      gap_q   <= '0;
      addr_q  <= '0;
      data_q  <= '0;
      en_q    <= 1'b0;
      wr_q    <= 1'b0;
      rv_q    <= 1'b0;
      rw_q    <= 1'b0;
      rd_q    <= '0;
      rl_q    <= '0;
      rt_q    <= 1'b0;
      dc_q    <= '0;
      tc_q    <= '0;
      busy_q  <= 1'b0;
    end else begin
      wp_q    <= wp_d;
      rp_q    <= rp_d;
      state_q <= state_d;
      lat_q   <= lat_d;
      gap_q   <= gap_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
      en_q    <= en_d;
      wr_q    <= wr_d;
      rv_q    <= rv_d;
      rw_q    <= rw_d;
      rd_q    <= rd_d;
      rl_q    <= rl_d;
      rt_q    <= rt_d;
      dc_q    <= dc_d;
      tc_q    <= tc_d;
      busy_q  <= busy_d;
    end
  end

  assign addrOut      = addr_q;
  assign dataOut      = data_q;
  assign enableOut    = en_q;
  assign writeOut     = wr_q;
  assign respValid    = rv_q;
  assign respWrite    = rw_q;
  assign respData     = rd_q;
  assign respLatency  = rl_q;
  assign respTimeout  = rt_q;
  assign doneCount    = dc_q;
  assign timeoutCount = tc_q;
  assign busy         = busy_q;

endmodule

// File: tb/tb_cache_requester.sv
// Bench for cache_requester: vector table plus FIFO-full,
// timeout and mid-request reset sequences against a cache model.
module tb_cache_requester;

  localparam int AL = 11;
  localparam int RS = 32;
  localparam int FD = 4;
  localparam int TO = 16;
  localparam int GC = 1;
  localparam int LW = $clog2(TO+1);

  logic          clock = 1'b0;
  logic          reset = 1'b0;
  logic          cmdValid = 1'b0;
  logic          cmdReady;
  logic          cmdWrite = 1'b0;
  logic [AL-1:0] cmdAddr = '0;
  logic [RS-1:0] cmdData = '0;
  logic [AL-1:0] addrOut;
  logic [RS-1:0] dataOut;
  logic          enableOut;
  logic          writeOut;
  logic [RS-1:0] dataIn = '0;
  logic          fetchComplete = 1'b0;
  logic          writeComplete = 1'b0;
  logic          respValid;
  logic          respWrite;
  logic [RS-1:0] respData;
  logic [LW-1:0] respLatency;
  logic          respTimeout;
  logic [15:0]   doneCount;
  logic [15:0]   timeoutCount;
  logic          busy;

  cache_requester #(
    .ADDR_LENGTH(AL), .RETURN_SIZE(RS), .FIFO_DEPTH(FD),
    .TIMEOUT(TO), .GAP_CYCLES(GC)
  ) dut (
    .clock(clock), .reset(reset),
    .cmdValid(cmdValid), .cmdReady(cmdReady),
    .cmdWrite(cmdWrite), .cmdAddr(cmdAddr), .cmdData(cmdData),
    .addrOut(addrOut), .dataOut(dataOut),
    .enableOut(enableOut), .writeOut(writeOut),
    .dataIn(dataIn), .fetchComplete(fetchComplete),
    .writeComplete(writeComplete),
    .respValid(respValid), .respWrite(respWrite),
    .respData(respData), .respLatency(respLatency),
    .respTimeout(respTimeout), .doneCount(doneCount),
    .timeoutCount(timeoutCount), .busy(busy)
  );

  always #5 clock = ~clock;

  int pass_n = 0;
  int tot_n  = 0;

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    tot_n++;
    if (act === exp) pass_n++;
    else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
  endtask

  // Cache model: completes once enable has been high tgt cycles.
  int          tgt = 0;
  bit          use_wc = 1'b0;
  logic [31:0] mdata = '0;
  int          ecnt = 0;

  typedef struct {
    logic          w;
    logic [RS-1:0] d;
    logic [LW-1:0] l;
    logic          t;
    logic [AL-1:0] a;
  } rec_t;
  rec_t rq[$];

  bit prev_rv = 1'b0;
  bit prev_en = 1'b0;
  bit chk_gap = 1'b0;
  int hi_run = 0;
  int lo_run = 0;
  int last_hi = 0;

  always @(negedge clock) begin
    if (respValid) begin
      chk("rv_single", {63'd0, prev_rv}, 64'd0);
      rq.push_back('{respWrite, respData, respLatency,
                     respTimeout, addrOut});
    end
    prev_rv = respValid;
    if (enableOut) begin
      if (!prev_en && chk_gap) chk("gap", lo_run, GC);
      hi_run++;
      lo_run = 0;
    end else begin
      if (prev_en) last_hi = hi_run;
      hi_run = 0;
      lo_run++;
    end
    prev_en = enableOut;
    if (enableOut) ecnt++;
    else ecnt = 0;
    fetchComplete = 1'b0;
    writeComplete = 1'b0;
    dataIn = '0;
    if (enableOut && tgt != 0 && ecnt >= tgt) begin
      if (use_wc) writeComplete = 1'b1;
      else begin
        fetchComplete = 1'b1;
        dataIn = mdata;
      end
    end
  end

  task automatic push(input logic w, input logic [AL-1:0] a,
                      input logic [RS-1:0] d);
    int n;
    n = 0;
    @(negedge clock);
    cmdValid = 1'b1;
    cmdWrite = w;
    cmdAddr  = a;
    cmdData  = d;
    while (!cmdReady && n < 200) begin
      @(negedge clock);
      n++;
    end
    if (!cmdReady) chk("push_bound", 0, 1);
    @(posedge clock);
    #1;
    cmdValid = 1'b0;
  endtask

  task automatic wait_en();
    int n;
    n = 0;
    while (!enableOut && n < 20) begin
      @(negedge clock);
      n++;
    end
    chk("en_rise", {63'd0, enableOut}, 64'd1);
  endtask

  task automatic wait_resp(output rec_t r);
    int n;
    n = 0;
    while (rq.size() == 0 && n < 60) begin
      @(negedge clock);
      #1;
      n++;
    end
    if (rq.size() == 0) begin
      chk("resp_bound", 0, 1);
      r = '{1'b0, '0, '0, 1'b0, '0};
    end else begin
      r = rq.pop_front();
    end
  endtask

  typedef struct {
    logic          w;
    logic [AL-1:0] a;
    logic [RS-1:0] d;
    int            tg;
    bit            wc;
    logic [31:0]   md;
    logic [31:0]   ed;
    int            el;
    logic          et;
  } vec_t;
  vec_t vt[7];

  int exp_done = 0;
  int exp_to = 0;

  task automatic run_vec(input vec_t v);
    rec_t r;
    tgt = v.tg;
    use_wc = v.wc;
    mdata = v.md;
    push(v.w, v.a, v.d);
    wait_en();
    chk("addrOut", addrOut, v.a);
    chk("writeOut", writeOut, v.w);
    if (v.w) chk("dataOut", dataOut, v.d);
    wait_resp(r);
    chk("respWrite", r.w, v.w);
    chk("respData", r.d, v.ed);
    chk("respLatency", r.l, v.el);
    chk("respTimeout", r.t, v.et);
    chk("respAddr", r.a, v.a);
    if (v.et) begin
      exp_to++;
      chk("hi_run", last_hi, TO);
    end else begin
      exp_done++;
    end
    chk("doneCount", doneCount, exp_done);
    chk("timeoutCount", timeoutCount, exp_to);
  endtask

  initial begin
    rec_t r;
    vt[0] = '{1'b0, 11'h000, 32'h0, 11, 1'b0,
              32'hDEADBEEF, 32'hDEADBEEF, 11, 1'b0};
    vt[1] = '{1'b1, 11'h004, 32'hFFFFFFFF, 3, 1'b1,
              32'h0, 32'h0, 3, 1'b0};
    vt[2] = '{1'b0, 11'h7FF, 32'h0, 1, 1'b0,
              32'h12345678, 32'h12345678, 1, 1'b0};
    vt[3] = '{1'b1, 11'h123, 32'hCAFEF00D, 2, 1'b0,
              32'h99999999, 32'h0, 2, 1'b0};
    vt[4] = '{1'b0, 11'h055, 32'h0, 4, 1'b1,
              32'h11111111, 32'h0, TO, 1'b1};
    vt[5] = '{1'b0, 11'h066, 32'h0, TO, 1'b0,
              32'h0BADC0DE, 32'h0BADC0DE, TO, 1'b0};
    vt[6] = '{1'b1, 11'h3FF, 32'h00000001, 5, 1'b1,
              32'h0, 32'h0, 5, 1'b0};

    #12;
    chk("rst_en", {63'd0, enableOut}, 64'd0);
    chk("rst_rv", {63'd0, respValid}, 64'd0);
    chk("rst_busy", {63'd0, busy}, 64'd0);
    chk("rst_ready", {63'd0, cmdReady}, 64'd1);
    chk("rst_addr", addrOut, 0);
    chk("rst_cnts", {doneCount, timeoutCount}, 0);
    @(negedge clock);
    reset = 1'b1;

    for (int i = 0; i < 7; i++) run_vec(vt[i]);

    // FIFO fill while the head request is stalled
    tgt = 0;
    use_wc = 1'b0;
    mdata = 32'hA5A50000;
    push(1'b0, 11'h100, '0);
    wait_en();
    for (int i = 1; i < 5; i++) push(1'b0, AL'(11'h100 + i), '0);
    chk("cmdReady_full", {63'd0, cmdReady}, 64'd0);
    chk("busy_full", {63'd0, busy}, 64'd1);
    tgt = 2;
    push(1'b0, 11'h105, '0);
    chk_gap = 1'b1;
    for (int i = 0; i < 6; i++) begin
      wait_resp(r);
      chk("fifo_addr", r.a, 11'h100 + i);
      chk("fifo_data", r.d, 32'hA5A50000);
      chk("fifo_tmo", r.t, 0);
      if (i > 0) chk("fifo_lat", r.l, 2);
    end
    chk_gap = 1'b0;
    exp_done += 6;
    repeat (4) @(negedge clock);
    chk("fifo_done", doneCount, exp_done);
    chk("fifo_idle", {63'd0, busy}, 64'd0);

    // Reset in the middle of an issued request
    tgt = 0;
    push(1'b0, 11'h022, '0);
    wait_en();
    repeat (4) @(negedge clock);
    #2;
    reset = 1'b0;
    #1;
    chk("mr_en", {63'd0, enableOut}, 64'd0);
    chk("mr_busy", {63'd0, busy}, 64'd0);
    chk("mr_ready", {63'd0, cmdReady}, 64'd1);
    chk("mr_cnts", {doneCount, timeoutCount}, 0);
    chk("mr_addr", addrOut, 0);
    repeat (3) @(negedge clock);
    #1;
    chk("mr_noresp", rq.size(), 0);
    @(negedge clock);
    reset = 1'b1;
    exp_done = 0;
    exp_to = 0;
    run_vec(vt[0]);

    $display("%0d/%0d checks passed", pass_n, tot_n);
    $finish;
  end

endmodule
